// File: rtl/dram_timing.sv
// DRAM RAS/CAS/WE and row/column mux sequencer for the VG8020 main RAM.
// Follows Z80 memory cycles; RAS-only refresh during M1 refresh.
module dram_timing #(
    parameter int unsigned T_RAH = 1,
    parameter int unsigned T_ASC = 1,
    parameter int unsigned T_RP  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mreq_n,
    input  logic rd_n,
    input  logic wr_n,
    input  logic rfsh_n,
    output logic ras_n,
    output logic cas_n,
    output logic we_n,
    output logic mux,
    output logic wait_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_ACCESS,
        S_REFRESH,
        S_PRECHARGE
    } state_e;

    localparam logic [3:0] RAH_LD = 4'(T_RAH - 1);
    localparam logic [3:0] ASC_LD = 4'(T_ASC - 1);
    localparam logic [3:0] RP_LD  = 4'(T_RP - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ras_n_q, ras_n_d;
    logic       cas_n_q, cas_n_d;
    logic       we_n_q, we_n_d;
    logic       mux_q, mux_d;
    logic       wait_n_q, wait_n_d;
    logic       cnt_zero;

    assign cnt_zero = (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? 4'd0 : cnt_q - 4'd1;
        unique case (state_q)
            S_IDLE: begin
                if (!mreq_n) begin
                    if (rfsh_n) begin
                        state_d = S_ROW;
                        cnt_d   = RAH_LD;
                    end else begin
                        state_d = S_REFRESH;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_ROW: begin
                if (mreq_n) begin
                    state_d = S_PRECHARGE;
                    cnt_d   = RP_LD;
                end else if (cnt_zero) begin
                    state_d = S_COL;
                    cnt_d   = ASC_LD;
                end
            end
            S_COL: begin
                if (mreq_n) begin
                    state_d = S_PRECHARGE;
                    cnt_d   = RP_LD;
                end else if (cnt_zero && (!rd_n || !wr_n)) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'd0;
                end
            end
            S_ACCESS, S_REFRESH: begin
                if (mreq_n) begin
                    state_d = S_PRECHARGE;
                    cnt_d   = RP_LD;
                end
            end
            S_PRECHARGE: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Strobes are registered images of the state being entered.
    always_comb begin
        ras_n_d  = !(state_d == S_ROW || state_d == S_COL
                  || state_d == S_ACCESS || state_d == S_REFRESH);
        cas_n_d  = (state_d != S_ACCESS);
        mux_d    = (state_d == S_COL || state_d == S_ACCESS);
        we_n_d   = 1'b1;
        if (state_d == S_ACCESS) begin
            we_n_d = (state_q == S_ACCESS) ? we_n_q : wr_n;
        end
        wait_n_d = !(state_d == S_PRECHARGE && !mreq_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            ras_n_q  <= 1'b1;
            cas_n_q  <= 1'b1;
            we_n_q   <= 1'b1;
            mux_q    <= 1'b0;
            wait_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ras_n_q  <= ras_n_d;
            cas_n_q  <= cas_n_d;
            we_n_q   <= we_n_d;
            mux_q    <= mux_d;
            wait_n_q <= wait_n_d;
        end
    end

    assign ras_n  = ras_n_q;
    assign cas_n  = cas_n_q;
    assign we_n   = we_n_q;
    assign mux    = mux_q;
    assign wait_n = wait_n_q;

endmodule

// File: tb/tb_dram_timing.sv
// Directed scoreboard bench for dram_timing: default and overridden timing.
module tb_dram_timing;

    localparam logic [4:0] IDL = 5'b11101;
    localparam logic [4:0] PRW = 5'b11100;
    localparam logic [4:0] ROW = 5'b01101;
    localparam logic [4:0] COL = 5'b01111;
    localparam logic [4:0] ARD = 5'b00111;
    localparam logic [4:0] AWR = 5'b00011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mreq_n = 1'b1;
    logic rd_n = 1'b1;
    logic wr_n = 1'b1;
    logic rfsh_n = 1'b1;
    logic ras_n1, cas_n1, we_n1, mux1, wait_n1;
    logic ras_n2, cas_n2, we_n2, mux2, wait_n2;

    typedef struct {
        logic [4:0] exp;
        bit         sel2;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    dram_timing dut1 (
        .clk(clk), .rst(rst), .mreq_n(mreq_n), .rd_n(rd_n),
        .wr_n(wr_n), .rfsh_n(rfsh_n), .ras_n(ras_n1), .cas_n(cas_n1),
        .we_n(we_n1), .mux(mux1), .wait_n(wait_n1)
    );

    dram_timing #(.T_RAH(2), .T_ASC(1), .T_RP(3)) dut2 (
        .clk(clk), .rst(rst), .mreq_n(mreq_n), .rd_n(rd_n),
        .wr_n(wr_n), .rfsh_n(rfsh_n), .ras_n(ras_n2), .cas_n(cas_n2),
        .we_n(we_n2), .mux(mux2), .wait_n(wait_n2)
    );

    // Drive inputs for the next rising edge and queue the expected
    // {ras_n,cas_n,we_n,mux,wait_n} seen just after that edge.
    task automatic step(input logic rs, input logic m, input logic r,
                        input logic w, input logic f, input logic [4:0] e,
                        input bit s2, input string nm);
        exp_t x;
        @(negedge clk);
        rst = rs;
        mreq_n = m;
        rd_n = r;
        wr_n = w;
        rfsh_n = f;
        x.exp = e;
        x.sel2 = s2;
        x.name = nm;
        sbq.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        logic [4:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                act = x.sel2 ? {ras_n2, cas_n2, we_n2, mux2, wait_n2}
                             : {ras_n1, cas_n1, we_n1, mux1, wait_n1};
                n_chk++;
                if (act !== x.exp)
                    $display("FAIL %s: got %b expected %b (ras,cas,we,mux,wait)",
                             x.name, act, x.exp);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        // reset
        step(1, 1, 1, 1, 1, IDL, 0, "reset");
        // read
        step(0, 0, 0, 1, 1, ROW, 0, "rd@0 ras");
        step(0, 0, 0, 1, 1, COL, 0, "rd@1 mux");
        step(0, 0, 0, 1, 1, ARD, 0, "rd@2 cas");
        for (int i = 3; i < 6; i++)
            step(0, 0, 0, 1, 1, ARD, 0, $sformatf("rd@%0d hold", i));
        step(0, 1, 1, 1, 1, IDL, 0, "rd@6 release");
        step(0, 1, 1, 1, 1, IDL, 0, "rd@7 pre");
        step(0, 1, 1, 1, 1, IDL, 0, "rd@8 idle");
        // write with late wr_n; wr_n raised mid-access, we_n stays low
        step(0, 0, 1, 1, 1, ROW, 0, "wr@0 ras");
        for (int i = 1; i < 4; i++)
            step(0, 0, 1, 1, 1, COL, 0, $sformatf("wr@%0d col wait", i));
        step(0, 0, 1, 0, 1, AWR, 0, "wr@4 cas we");
        step(0, 0, 1, 0, 1, AWR, 0, "wr@5 hold");
        step(0, 0, 1, 1, 1, AWR, 0, "wr@6 we held");
        step(0, 0, 1, 1, 1, AWR, 0, "wr@7 we held");
        step(0, 1, 1, 1, 1, IDL, 0, "wr@8 release");
        step(0, 1, 1, 1, 1, IDL, 0, "wr@9 pre");
        step(0, 1, 1, 1, 1, IDL, 0, "wr@10 idle");
        // refresh
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 1, 0, ROW, 0, $sformatf("rf@%0d ras only", i));
        step(0, 1, 1, 1, 1, IDL, 0, "rf@3 release");
        step(0, 1, 1, 1, 1, IDL, 0, "rf@4 pre");
        step(0, 1, 1, 1, 1, IDL, 0, "rf@5 idle");
        // back-to-back
        step(0, 0, 0, 1, 1, ROW, 0, "bb@0 ras");
        step(0, 0, 0, 1, 1, COL, 0, "bb@1 mux");
        for (int i = 2; i < 6; i++)
            step(0, 0, 0, 1, 1, ARD, 0, $sformatf("bb@%0d cas", i));
        step(0, 1, 1, 1, 1, IDL, 0, "bb@6 release");
        step(0, 0, 0, 1, 1, PRW, 0, "bb@7 wait low");
        step(0, 0, 0, 1, 1, IDL, 0, "bb@8 wait high");
        step(0, 0, 0, 1, 1, ROW, 0, "bb@9 ras");
        step(0, 0, 0, 1, 1, COL, 0, "bb@10 mux");
        step(0, 0, 0, 1, 1, ARD, 0, "bb@11 cas");
        step(0, 1, 1, 1, 1, IDL, 0, "bb@12 release");
        step(0, 1, 1, 1, 1, IDL, 0, "bb@13 pre");
        step(0, 1, 1, 1, 1, IDL, 0, "bb@14 idle");
        // abort from ROW
        step(0, 0, 0, 1, 1, ROW, 0, "abr@0 ras");
        step(0, 1, 0, 1, 1, IDL, 0, "abr@1 pre");
        step(0, 1, 1, 1, 1, IDL, 0, "abr@2 no cas");
        step(0, 1, 1, 1, 1, IDL, 0, "abr@3 idle");
        // abort from COL
        step(0, 0, 1, 1, 1, ROW, 0, "abc@0 ras");
        step(0, 0, 1, 1, 1, COL, 0, "abc@1 col");
        step(0, 1, 1, 1, 1, IDL, 0, "abc@2 pre");
        step(0, 1, 1, 1, 1, IDL, 0, "abc@3 no cas");
        step(0, 1, 1, 1, 1, IDL, 0, "abc@4 idle");
        // reset mid-access, pending request restarts from IDLE
        step(0, 0, 0, 1, 1, ROW, 0, "rma@0 ras");
        step(0, 0, 0, 1, 1, COL, 0, "rma@1 mux");
        step(0, 0, 0, 1, 1, ARD, 0, "rma@2 cas");
        step(1, 0, 0, 1, 1, IDL, 0, "rma@3 reset");
        step(0, 0, 0, 1, 1, ROW, 0, "rma@4 restart");
        step(0, 1, 1, 1, 1, IDL, 0, "rma@5 abort");
        // T_RAH=2, T_RP=3 instance
        step(1, 1, 1, 1, 1, IDL, 1, "p2 reset");
        step(0, 0, 0, 1, 1, ROW, 1, "p2@0 ras");
        step(0, 0, 0, 1, 1, ROW, 1, "p2@1 row hold");
        step(0, 0, 0, 1, 1, COL, 1, "p2@2 mux");
        step(0, 0, 0, 1, 1, ARD, 1, "p2@3 cas");
        step(0, 1, 1, 1, 1, IDL, 1, "p2@4 release");
        step(0, 0, 0, 1, 1, PRW, 1, "p2@5 wait");
        step(0, 0, 0, 1, 1, PRW, 1, "p2@6 wait");
        step(0, 0, 0, 1, 1, IDL, 1, "p2@7 idle");
        step(0, 0, 0, 1, 1, ROW, 1, "p2@8 ras");
        step(0, 1, 1, 1, 1, IDL, 1, "p2@9 abort");

        repeat (3) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
